window_gen_3x3: RTL and testbench

- Sliding-window generator that feeds the 3x3 MAC stage.
- Consumes a raster-order 8-bit pixel stream, one pixel per accepted beat.
- Buffers two previous image rows and emits a registered 3x3 window with a valid strobe that drives the MAC's in_valid and win00..win22 inputs.
- Produces "valid" (unpadded) windows only: (IMG_W-2)*(IMG_H-2) windows per frame.

---
 rtl/window_gen_3x3.sv | 129 ++++++++++++
 tb/tb_window_gen_3x3.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-order pixel stream to registered 3x3 sliding window.
// Two line buffers hold the previous two image rows. A window is flagged
// valid only when all nine taps lie inside the current frame.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | rows 0..1 being loaded into the line buffers, no window output
// RUN   | row >= 2, a window completes at every accepted beat with col >= 2
module window_gen_3x3 #(
  parameter  int IMG_W  = 28,
  parameter  int IMG_H  = 28,
  parameter  int DATA_W = 8,
  localparam int CW     = $clog2(IMG_W),
  localparam int RW     = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_in,
  output logic [DATA_W-1:0] win00,
  output logic [DATA_W-1:0] win01,
  output logic [DATA_W-1:0] win02,
  output logic [DATA_W-1:0] win10,
  output logic [DATA_W-1:0] win11,
  output logic [DATA_W-1:0] win12,
  output logic [DATA_W-1:0] win20,
  output logic [DATA_W-1:0] win21,
  output logic [DATA_W-1:0] win22,
  output logic              win_valid,
  output logic              frame_done,
  output logic [RW-1:0]     row_cnt,
  output logic [CW-1:0]     col_cnt
);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} phase_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  phase_t            phase_q, phase_d;
  logic [CW-1:0]     col_d;
  logic [RW-1:0]     row_d;
  logic              valid_d;
  logic              done_d;
  logic              accept;

  // Line buffers: lb1 holds row r-1, lb0 holds row r-2, both indexed by column.
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];

  // clear wins over a simultaneous pixel beat.
  assign accept = pix_valid & ~clear;

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= FILL;
    else        phase_q <= phase_d;
  end

  // Next position, next phase and the registered strobes.
  always_comb begin
    phase_d = phase_q;
    col_d   = col_cnt;
    row_d   = row_cnt;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (clear) begin
      phase_d = FILL;
      col_d   = '0;
      row_d   = '0;
    end else if (pix_valid) begin
      // Columns 0 and 1 would straddle the previous row, so they never complete a window.
      valid_d = (phase_q == RUN) && (col_cnt >= COL_TWO);
      if (col_cnt == COL_LAST) begin
        col_d = '0;
        if (row_cnt == ROW_LAST) begin
          row_d   = '0;
          phase_d = FILL;
          done_d  = 1'b1;
        end else begin
          row_d = row_cnt + 1'b1;
          if (row_d >= ROW_TWO) phase_d = RUN;
        end
      end else begin
        col_d = col_cnt + 1'b1;
      end
    end
  end

  // Position counters and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_cnt    <= col_d;
      row_cnt    <= row_d;
      win_valid  <= valid_d;
      frame_done <= done_d;
    end
  end

  // Window shift: columns move left, new right column comes from the line buffers and the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win00 <= '0; win01 <= '0; win02 <= '0;
      win10 <= '0; win11 <= '0; win12 <= '0;
      win20 <= '0; win21 <= '0; win22 <= '0;
    end else if (accept) begin
      win00 <= win01; win01 <= win02; win02 <= lb0[col_cnt];
      win10 <= win11; win11 <= win12; win12 <= lb1[col_cnt];
      win20 <= win21; win21 <= win22; win22 <= pix_in;
    end
  end

  // Line buffer update; contents are overwritten before use, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col_cnt] <= lb1[col_cnt];
      lb1[col_cnt] <= pix_in;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 5x4 instance for the scenario checks
// and a default 28x28 instance for the full-frame count.
module tb_window_gen_3x3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Small instance (5x4).
  logic       s_clear = 1'b0, s_pix_valid = 1'b0;
  logic [7:0] s_pix_in = '0;
  logic [7:0] s_win00, s_win01, s_win02, s_win10, s_win11, s_win12, s_win20, s_win21, s_win22;
  logic       s_win_valid, s_frame_done;
  logic [1:0] s_row_cnt;
  logic [2:0] s_col_cnt;

  window_gen_3x3 #(.IMG_W(5), .IMG_H(4), .DATA_W(8)) u_small (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .pix_valid(s_pix_valid), .pix_in(s_pix_in),
    .win00(s_win00), .win01(s_win01), .win02(s_win02),
    .win10(s_win10), .win11(s_win11), .win12(s_win12),
    .win20(s_win20), .win21(s_win21), .win22(s_win22),
    .win_valid(s_win_valid), .frame_done(s_frame_done),
    .row_cnt(s_row_cnt), .col_cnt(s_col_cnt)
  );

  // Default instance (28x28).
  logic       b_clear = 1'b0, b_pix_valid = 1'b0;
  logic [7:0] b_pix_in = '0;
  logic [7:0] b_win00, b_win01, b_win02, b_win10, b_win11, b_win12, b_win20, b_win21, b_win22;
  logic       b_win_valid, b_frame_done;
  logic [4:0] b_row_cnt;
  logic [4:0] b_col_cnt;

  window_gen_3x3 u_big (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .pix_valid(b_pix_valid), .pix_in(b_pix_in),
    .win00(b_win00), .win01(b_win01), .win02(b_win02),
    .win10(b_win10), .win11(b_win11), .win12(b_win12),
    .win20(b_win20), .win21(b_win21), .win22(b_win22),
    .win_valid(b_win_valid), .frame_done(b_frame_done),
    .row_cnt(b_row_cnt), .col_cnt(b_col_cnt)
  );

  // Reference position of the small instance and the frame's pixel base.
  int s_row = 0, s_col = 0, s_base = 0, s_nwin = 0;
  int b_row = 0, b_col = 0, b_nwin = 0, b_ndone = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pix(input int base, input int w, input int r, input int c);
    return (base + r * w + c) % 256;
  endfunction

  // One clock of stimulus on the small instance, then check against the reference.
  task automatic s_beat(input bit v, input bit clr);
    bit acc, ev, ed;
    int obs [9];
    @(negedge clk);
    s_pix_valid = v;
    s_clear     = clr;
    s_pix_in    = 8'(pix(s_base, 5, s_row, s_col));
    @(posedge clk);
    #1;
    acc = v && !clr;
    ev  = acc && s_row >= 2 && s_col >= 2;
    ed  = acc && s_row == 3 && s_col == 4;
    chk("s_win_valid", s_win_valid, ev);
    chk("s_frame_done", s_frame_done, ed);
    if (ev) begin
      obs = '{s_win00, s_win01, s_win02, s_win10, s_win11, s_win12, s_win20, s_win21, s_win22};
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("s_win%0d%0d", i, j), obs[i*3+j], pix(s_base, 5, s_row - 2 + i, s_col - 2 + j));
      s_nwin++;
    end
    if (clr) begin
      s_row = 0; s_col = 0;
    end else if (acc) begin
      if (s_col == 4) begin
        s_col = 0;
        s_row = (s_row == 3) ? 0 : s_row + 1;
      end else s_col++;
    end
    chk("s_row_cnt", s_row_cnt, s_row);
    chk("s_col_cnt", s_col_cnt, s_col);
  endtask

  task automatic b_beat(input bit v);
    bit ev, ed;
    @(negedge clk);
    b_pix_valid = v;
    b_pix_in    = 8'(pix(0, 28, b_row, b_col));
    @(posedge clk);
    #1;
    ev = v && b_row >= 2 && b_col >= 2;
    ed = v && b_row == 27 && b_col == 27;
    chk("b_win_valid", b_win_valid, ev);
    chk("b_frame_done", b_frame_done, ed);
    if (b_win_valid) b_nwin++;
    if (b_frame_done) b_ndone++;
    if (ev) begin
      chk("b_win22", b_win22, pix(0, 28, b_row, b_col));
      chk("b_win00", b_win00, pix(0, 28, b_row - 2, b_col - 2));
    end
    if (v) begin
      if (b_col == 27) begin
        b_col = 0;
        b_row = (b_row == 27) ? 0 : b_row + 1;
      end else b_col++;
    end
  endtask

  initial begin
    int sent;
    #1;
    chk("rst_win_valid", s_win_valid, 0);
    chk("rst_frame_done", s_frame_done, 0);
    chk("rst_win22", s_win22, 0);
    chk("rst_row_cnt", s_row_cnt, 0);
    chk("rst_col_cnt", s_col_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame, pixel = index.
    s_nwin = 0;
    for (int idx = 0; idx < 20; idx++) begin
      s_beat(1, 0);
      if (idx == 12) begin
        chk("first_valid", s_win_valid, 1);
        chk("first_w00", s_win00, 0);
        chk("first_w02", s_win02, 2);
        chk("first_w10", s_win10, 5);
        chk("first_w12", s_win12, 7);
        chk("first_w20", s_win20, 10);
        chk("first_w22", s_win22, 12);
      end
      if (idx == 19) begin
        chk("last_w00", s_win00, 7);
        chk("last_w22", s_win22, 19);
        chk("last_done", s_frame_done, 1);
      end
    end
    chk("cont_nwin", s_nwin, 6);

    // Same frame with random gaps.
    s_nwin = 0;
    sent = 0;
    for (int k = 0; k < 400 && sent < 20; k++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      s_beat(v, 0);
      if (v) sent++;
    end
    chk("gap_completed", sent, 20);
    s_beat(0, 0);
    chk("gap_nwin", s_nwin, 6);

    // Back-to-back frames; second frame offset by 100.
    s_nwin = 0;
    s_base = 0;
    for (int idx = 0; idx < 20; idx++) s_beat(1, 0);
    s_base = 100;
    for (int idx = 0; idx < 20; idx++) begin
      s_beat(1, 0);
      if (idx == 12) begin
        chk("f2_first_w00", s_win00, 100);
        chk("f2_first_w22", s_win22, 112);
      end
    end
    s_beat(0, 0);
    chk("b2b_nwin", s_nwin, 12);
    s_base = 0;

    // Clear after pixel 9 (with a dropped beat), then a full restart.
    for (int idx = 0; idx < 10; idx++) s_beat(1, 0);
    s_beat(1, 1);
    chk("clr_row_cnt", s_row_cnt, 0);
    chk("clr_col_cnt", s_col_cnt, 0);
    s_nwin = 0;
    for (int idx = 0; idx < 20; idx++) s_beat(1, 0);
    s_beat(0, 0);
    chk("clr_nwin", s_nwin, 6);

    // Reset in the middle of row 3, right after a valid window.
    for (int idx = 0; idx < 18; idx++) s_beat(1, 0);
    chk("pre_rst_valid", s_win_valid, 1);
    @(negedge clk);
    s_pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_win_valid", s_win_valid, 0);
    chk("mrst_win00", s_win00, 0);
    chk("mrst_win11", s_win11, 0);
    chk("mrst_win22", s_win22, 0);
    chk("mrst_row_cnt", s_row_cnt, 0);
    chk("mrst_col_cnt", s_col_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s_row = 0; s_col = 0;
    s_nwin = 0;
    for (int idx = 0; idx < 20; idx++) s_beat(1, 0);
    s_beat(0, 0);
    chk("rst_nwin", s_nwin, 6);

    // Full default-size frame.
    for (int idx = 0; idx < 28 * 28; idx++) b_beat(1);
    b_beat(0);
    chk("big_nwin", b_nwin, 676);
    chk("big_ndone", b_ndone, 1);
    chk("big_row_cnt", b_row_cnt, 0);
    chk("big_col_cnt", b_col_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
